// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } pwm_dir_t;

  // All-ones value of an n-bit counter.
  function automatic logic [63:0] pwm_max(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: tick fires every prescale+1 clocks while enabled.
module pwm_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // >= rather than == so a shrinking prescale cannot strand pcnt above the limit.
  always_comb begin
    tick   = ena & (pcnt_q >= prescale);
    pcnt_d = pcnt_q;
    if (!ena || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center counter, per-channel compare and
// double-buffered duty/mode registers that swap only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PW       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [CHANNELS-1:0]   ch_ena,
  input  logic [PW-1:0]         prescale,
  input  pwm_mode_t             mode,
  input  logic [CHANNELS*N-1:0] duty_in,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [CHANNELS-1:0]   out,
  output logic                  period_start
);

  localparam logic [N-1:0] Max = N'(pwm_max(N));
  localparam logic [N-1:0] One = N'(1);

  logic                  tick;
  logic                  pb;
  logic                  accept;
  logic                  xfer;
  logic                  mode_change;
  logic [N-1:0]          cnt_q;
  pwm_dir_t              dir_q;
  pwm_mode_t             act_mode_q;
  pwm_mode_t             shadow_mode_q;
  logic [CHANNELS*N-1:0] act_duty_q;
  logic [CHANNELS*N-1:0] shadow_duty_q;
  logic                  pending_q;
  logic [CHANNELS-1:0]   out_d;

  pwm_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .prescale(prescale),
    .tick    (tick)
  );

  // Center mode ends its period on the down-step from 1 to 0.
  assign pb = tick & ((act_mode_q == PWM_EDGE) ? (cnt_q == Max)
                                               : ((cnt_q == One) && (dir_q == DirDown)));

  assign wr_ready    = ~pending_q;
  assign accept      = wr_valid & ~pending_q;
  assign xfer        = pending_q & (pb | ~ena);
  assign mode_change = xfer & (shadow_mode_q != act_mode_q);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
    logic [N-1:0] duty;
    assign duty     = act_duty_q[c*N +: N];
    assign out_d[c] = ena & ch_ena[c] & ((cnt_q < duty) | (duty == Max));
  end

  // Counter / direction FSM with the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      dir_q        <= DirUp;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_d;
      period_start <= pb;
      if (!ena || mode_change) begin
        cnt_q <= '0;
        dir_q <= DirUp;
      end else if (tick) begin
        if (act_mode_q == PWM_EDGE) begin
          cnt_q <= cnt_q + One;
        end else if (dir_q == DirUp) begin
          if (cnt_q == Max) begin
            cnt_q <= Max - One;
            dir_q <= DirDown;
          end else begin
            cnt_q <= cnt_q + One;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_q <= One;
            dir_q <= DirUp;
          end else begin
            cnt_q <= cnt_q - One;
          end
        end
      end
    end
  end

  // Shadow/active duty registers; accept and transfer are mutually exclusive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q     <= 1'b0;
      shadow_duty_q <= '0;
      shadow_mode_q <= PWM_EDGE;
      act_duty_q    <= '0;
      act_mode_q    <= PWM_EDGE;
    end else if (accept) begin
      shadow_duty_q <= duty_in;
      shadow_mode_q <= mode;
      pending_q     <= 1'b1;
    end else if (xfer) begin
      act_duty_q    <= shadow_duty_q;
      act_mode_q    <= shadow_mode_q;
      pending_q     <= 1'b0;
    end
  end

endmodule
